// File: rtl/dataflow_cond_br.sv
// Buffered conditional-branch node: joins a predicate and a data stream, queues
// the joined pairs in a small FIFO and steers each data token to the true or false branch.
module dataflow_cond_br #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cond_valid,
  output logic                     cond_ready,
  input  logic                     cond_data,
  input  logic                     data_valid,
  output logic                     data_ready,
  input  logic [WIDTH-1:0]         data_data,
  output logic                     true_valid,
  input  logic                     true_ready,
  output logic [WIDTH-1:0]         true_data,
  output logic                     false_valid,
  input  logic                     false_ready,
  output logic [WIDTH-1:0]         false_data,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DEPTH-1:0] mem_cond;
  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic full;
  logic empty;
  logic enq;
  logic deq;
  logic head_cond;
  logic [WIDTH-1:0] head_data;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Each side's ready depends only on the other side's valid and the fill level,
  // never on the consumers, so no combinational path runs from output to input.
  assign cond_ready = data_valid & ~full;
  assign data_ready = cond_valid & ~full;
  assign enq        = cond_valid & data_valid & ~full;

  assign head_cond = mem_cond[rd_ptr];
  assign head_data = mem_data[rd_ptr];

  always_comb begin
    true_valid  = ~empty & head_cond;
    false_valid = ~empty & ~head_cond;
    true_data   = empty ? '0 : head_data;
    false_data  = empty ? '0 : head_data;
  end

  assign deq       = (true_valid & true_ready) | (false_valid & false_ready);
  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cond <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem_cond[wr_ptr] <= cond_data;
        mem_data[wr_ptr] <= data_data;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
